// File: rtl/cache_driver_pkg.sv
// Shared definitions for the cache_driver walking-ones tester:
// FSM encoding, pattern length and error-counter sizing.
package cache_driver_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int PATTERN_LEN = 8;
  localparam int IDX_W       = $clog2(PATTERN_LEN);
  localparam int ERR_W       = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/cache_driver_wait_timer.sv
// Per-transaction wait counter: cleared by restart, counts up and parks at
// timeout-1, where expired is raised.
module wait_timer #(
  parameter int timeout = 16,
  parameter int cnt_w   = $clog2(timeout + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             restart,
  output logic             expired,
  output logic [cnt_w-1:0] count
);

  logic [cnt_w-1:0] r_count;

  assign expired = (r_count == cnt_w'(timeout - 1));
  assign count   = r_count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= '0;
    end else if (restart) begin
      r_count <= '0;
    end else if (!expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_driver.sv
// Cache exerciser: writes a walking-ones pattern to eight consecutive
// addresses, reads them back, and reports error count and first failing address.
module cache_driver
  import cache_driver_pkg::*;
#(
  parameter int                 d_width   = 8,
  parameter int                 a_width   = 8,
  parameter logic [a_width-1:0] base_addr = '0,
  parameter int                 timeout   = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               odv,
  input  logic [d_width-1:0] data_fromcache,
  output logic [a_width-1:0] addr_tocache,
  output logic [d_width-1:0] data_tocache,
  output logic               rw_tocache,
  output logic               ce_tocache,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [a_width-1:0] fail_addr
);

  localparam int CNT_W = $clog2(timeout + 1);

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic               r_rd_phase, w_rd_phase_next;
  logic [ERR_W-1:0]   r_err, w_err_next;
  logic [a_width-1:0] r_fail_addr, w_fail_addr_next;

  logic               w_in_txn;
  logic               w_err_evt;
  logic               w_expired;
  logic [CNT_W-1:0]   w_count;
  logic               w_unused_count;
  logic [a_width-1:0] w_addr;
  logic [d_width-1:0] w_pattern;

  assign w_in_txn  = (r_state == WRITE) || (r_state == READ);
  assign w_addr    = base_addr + a_width'(r_idx);
  assign w_pattern = {{(d_width-1){1'b0}}, 1'b1} << r_idx;

  // Timer is held clear outside WRITE/READ so each transaction starts at 0.
  wait_timer #(
    .timeout (timeout),
    .cnt_w   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .clr     (clr),
    .restart (!w_in_txn),
    .expired (w_expired),
    .count   (w_count)
  );

  assign w_unused_count = ^w_count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_rd_phase  <= 1'b0;
      r_err       <= '0;
      r_fail_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_rd_phase  <= w_rd_phase_next;
      r_err       <= w_err_next;
      r_fail_addr <= w_fail_addr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_rd_phase_next  = r_rd_phase;
    w_err_next       = r_err;
    w_fail_addr_next = r_fail_addr;
    w_err_evt        = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next     = WRITE;
          w_idx_next       = '0;
          w_rd_phase_next  = 1'b0;
          w_err_next       = '0;
          w_fail_addr_next = '0;
        end
      end
      WRITE: begin
        // odv wins over a simultaneous expiry
        if (odv) begin
          w_state_next = GAP;
        end else if (w_expired) begin
          w_state_next = GAP;
          w_err_evt    = 1'b1;
        end
      end
      READ: begin
        if (odv) begin
          w_state_next = GAP;
          w_err_evt    = (data_fromcache != w_pattern);
        end else if (w_expired) begin
          w_state_next = GAP;
          w_err_evt    = 1'b1;
        end
      end
      GAP: begin
        if (r_idx == IDX_W'(PATTERN_LEN - 1)) begin
          w_idx_next = '0;
          if (r_rd_phase) begin
            w_state_next = DONE;
          end else begin
            w_state_next    = READ;
            w_rd_phase_next = 1'b1;
          end
        end else begin
          w_idx_next   = r_idx + 1'b1;
          w_state_next = r_rd_phase ? READ : WRITE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_err_evt) begin
      if (r_err == '0) begin
        w_fail_addr_next = w_addr;
      end
      if (r_err != ERR_MAX) begin
        w_err_next = r_err + 1'b1;
      end
    end
  end

  assign ce_tocache   = w_in_txn;
  assign rw_tocache   = (r_state == READ);
  assign addr_tocache = w_in_txn ? w_addr : '0;
  assign data_tocache = (r_state == WRITE) ? w_pattern : '0;
  assign busy         = w_in_txn || (r_state == GAP);
  assign done         = (r_state == DONE);
  assign pass         = (r_state == DONE) && (r_err == '0);
  assign err_count    = r_err;
  assign fail_addr    = r_fail_addr;

endmodule
